// File: rtl/if_id_ctrl.sv
// Fetch-side controller: owns PC, the IF/ID pipeline register and I-cache miss/redirect tracking.
// One-cycle latency from fetch address to IF/ID; dcache_stall freezes everything, hazard_stall holds PC and IF/ID.
module if_id_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        hazard_flush,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        dcache_stall,
    input  logic        icache_stall,
    input  logic [31:0] ICACHE_rdata,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid,
    output logic [15:0] bubble_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] MISS       = 2'd1;
    localparam logic [1:0] MISS_REDIR = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_vld_q, ifid_vld_d;
    logic [15:0] bub_q, bub_d;
    logic        bubble;
    logic [31:0] tgt;

    assign tgt         = {branch_target[31:2], 2'b00};
    assign ICACHE_ren  = ~rst;
    assign ICACHE_addr = pc_q[31:2];
    assign IF_ID_pc    = ifid_pc_q;
    assign IF_ID_inst  = ifid_inst_q;
    assign IF_ID_valid = ifid_vld_q;
    assign bubble_cnt  = bub_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        ifid_pc_d   = ifid_pc_q;
        ifid_inst_d = ifid_inst_q;
        ifid_vld_d  = ifid_vld_q;
        bubble      = 1'b0;

        if (dcache_stall) begin
            // full freeze; upstream re-presents any branch once the cache releases
        end else if (branch_flag) begin
            bubble = 1'b1;
            if (icache_stall) begin
                pend_d  = tgt;
                state_d = MISS_REDIR;
            end else begin
                if (state_q == MISS_REDIR) begin
                    pend_d = tgt;
                end
                pc_d    = tgt;
                state_d = RUN;
            end
        end else if (icache_stall) begin
            if (state_q == RUN) begin
                state_d = MISS;
            end
            bubble = ~hazard_stall;
        end else if (state_q == MISS_REDIR) begin
            // the returning miss data belongs to the abandoned path
            pc_d    = pend_q;
            bubble  = 1'b1;
            state_d = RUN;
        end else begin
            state_d = RUN;
            if (hazard_stall) begin
                pc_d = pc_q;
            end else if (hazard_flush) begin
                pc_d   = pc_q + 32'd4;
                bubble = 1'b1;
            end else begin
                pc_d        = pc_q + 32'd4;
                ifid_pc_d   = pc_q;
                ifid_inst_d = ICACHE_rdata;
                ifid_vld_d  = 1'b1;
            end
        end

        if (bubble) begin
            ifid_inst_d = NOP;
            ifid_vld_d  = 1'b0;
        end
        bub_d = (bubble && (bub_q != 16'hFFFF)) ? bub_q + 16'd1 : bub_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= 32'd0;
            pend_q      <= 32'd0;
            ifid_pc_q   <= 32'd0;
            ifid_inst_q <= NOP;
            ifid_vld_q  <= 1'b0;
            bub_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            ifid_pc_q   <= ifid_pc_d;
            ifid_inst_q <= ifid_inst_d;
            ifid_vld_q  <= ifid_vld_d;
            bub_q       <= bub_d;
        end
    end

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed vectors with hand-computed post-edge expectations, checked by a decoupled scoreboard monitor.
module tb_if_id_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA = 32'hA0A0_0001, IB = 32'hB0B0_0002, IC = 32'hC0C0_0003,
                            ID = 32'hD0D0_0004, IE = 32'hE0E0_0005, IF = 32'hF0F0_0006,
                            IG = 32'h1234_0007, IH = 32'h5678_0008, JK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard_stall = 1'b0, hazard_flush = 1'b0, branch_flag = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        dcache_stall = 1'b0, icache_stall = 1'b0;
    logic [31:0] ICACHE_rdata = 32'd0;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] IF_ID_pc, IF_ID_inst;
    logic        IF_ID_valid;
    logic [15:0] bubble_cnt;

    if_id_ctrl dut (
        .clk(clk), .rst(rst),
        .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .dcache_stall(dcache_stall), .icache_stall(icache_stall),
        .ICACHE_rdata(ICACHE_rdata), .ICACHE_ren(ICACHE_ren), .ICACHE_addr(ICACHE_addr),
        .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ren;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] inst;
        logic        vld;
        logic [15:0] bc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string vname, input string field, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", vname, field, act, req);
        end
    endtask

    // Monitor: IF/ID and PC are presented every cycle, so each edge retires one expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_vec++;
                chk(e.name, "ren",   {31'd0, ICACHE_ren},  {31'd0, e.ren});
                chk(e.name, "addr",  {2'b00, ICACHE_addr}, {2'b00, e.pc[31:2]});
                chk(e.name, "ifpc",  IF_ID_pc,             e.ifpc);
                chk(e.name, "inst",  IF_ID_inst,           e.inst);
                chk(e.name, "valid", {31'd0, IF_ID_valid}, {31'd0, e.vld});
                chk(e.name, "bcnt",  {16'd0, bubble_cnt},  {16'd0, e.bc});
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected right after the following edge.
    task automatic vec(input string name, input logic r, input logic hs, input logic hf,
                       input logic bf, input logic [31:0] bt, input logic ds, input logic is,
                       input logic [31:0] rd, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                       input logic [31:0] e_inst, input logic e_v, input logic [15:0] e_bc);
        exp_t e;
        @(negedge clk);
        rst = r; hazard_stall = hs; hazard_flush = hf; branch_flag = bf;
        branch_target = bt; dcache_stall = ds; icache_stall = is; ICACHE_rdata = rd;
        e.name = name; e.ren = ~r; e.pc = e_pc; e.ifpc = e_ifpc;
        e.inst = e_inst; e.vld = e_v; e.bc = e_bc;
        exp_q.push_back(e);
    endtask

    initial begin
        //   name        rst hs hf bf target         ds is rdata  PC'           IF_ID_pc       inst v  bcnt
        vec("rst0",      1, 0, 0, 0, 32'h0,         0, 0, JK,   32'h0,         32'h0,         NOP, 0, 16'd0);
        vec("rst1",      1, 1, 1, 1, 32'h44,        0, 1, JK,   32'h0,         32'h0,         NOP, 0, 16'd0);
        vec("hitA",      0, 0, 0, 0, 32'h0,         0, 0, IA,   32'h4,         32'h0,         IA,  1, 16'd0);
        vec("hitB",      0, 0, 0, 0, 32'h0,         0, 0, IB,   32'h8,         32'h4,         IB,  1, 16'd0);
        vec("hitC",      0, 0, 0, 0, 32'h0,         0, 0, IC,   32'hC,         32'h8,         IC,  1, 16'd0);
        vec("hitD",      0, 0, 0, 0, 32'h0,         0, 0, ID,   32'h10,        32'hC,         ID,  1, 16'd0);
        vec("hzstl_fl",  0, 1, 1, 0, 32'h0,         0, 0, IE,   32'h10,        32'hC,         ID,  1, 16'd0);
        vec("flush",     0, 0, 1, 0, 32'h0,         0, 0, IE,   32'h14,        32'hC,         NOP, 0, 16'd1);
        vec("hitF",      0, 0, 0, 0, 32'h0,         0, 0, IF,   32'h18,        32'h14,        IF,  1, 16'd1);
        vec("hitG",      0, 0, 0, 0, 32'h0,         0, 0, IG,   32'h1C,        32'h18,        IG,  1, 16'd1);
        vec("hitH",      0, 0, 0, 0, 32'h0,         0, 0, IH,   32'h20,        32'h1C,        IH,  1, 16'd1);
        vec("br100",     0, 0, 0, 1, 32'h103,       0, 0, JK,   32'h100,       32'h1C,        NOP, 0, 16'd2);
        vec("hit100",    0, 0, 0, 0, 32'h0,         0, 0, IA,   32'h104,       32'h100,       IA,  1, 16'd2);
        vec("br40",      0, 0, 0, 1, 32'h40,        0, 0, JK,   32'h40,        32'h100,       NOP, 0, 16'd3);
        vec("miss1",     0, 0, 0, 0, 32'h0,         0, 1, JK,   32'h40,        32'h100,       NOP, 0, 16'd4);
        vec("miss2_br",  0, 0, 0, 1, 32'h200,       0, 1, JK,   32'h40,        32'h100,       NOP, 0, 16'd5);
        vec("miss3_hs",  0, 1, 0, 0, 32'h0,         0, 1, JK,   32'h40,        32'h100,       NOP, 0, 16'd5);
        vec("redir_end", 0, 0, 0, 0, 32'h0,         0, 0, IB,   32'h200,       32'h100,       NOP, 0, 16'd6);
        vec("hit200",    0, 0, 0, 0, 32'h0,         0, 0, IC,   32'h204,       32'h200,       IC,  1, 16'd6);
        vec("dc_frz",    0, 0, 0, 1, 32'h300,       1, 1, ID,   32'h204,       32'h200,       IC,  1, 16'd6);
        vec("dc_after",  0, 0, 0, 0, 32'h0,         0, 0, ID,   32'h208,       32'h204,       ID,  1, 16'd6);
        vec("mr_400",    0, 0, 0, 1, 32'h400,       0, 1, JK,   32'h208,       32'h204,       NOP, 0, 16'd7);
        vec("dc_in_mr",  0, 0, 0, 1, 32'h500,       1, 0, JK,   32'h208,       32'h204,       NOP, 0, 16'd7);
        vec("mr_end",    0, 0, 0, 0, 32'h0,         0, 0, IE,   32'h400,       32'h204,       NOP, 0, 16'd8);
        vec("mr_600",    0, 0, 0, 1, 32'h600,       0, 1, JK,   32'h400,       32'h204,       NOP, 0, 16'd9);
        vec("mr_br700",  0, 0, 0, 1, 32'h700,       0, 0, JK,   32'h700,       32'h204,       NOP, 0, 16'd10);
        vec("hit700",    0, 0, 0, 0, 32'h0,         0, 0, IF,   32'h704,       32'h700,       IF,  1, 16'd10);
        vec("miss_hs",   0, 1, 0, 0, 32'h0,         0, 1, JK,   32'h704,       32'h700,       IF,  1, 16'd10);
        vec("miss_nohs", 0, 0, 0, 0, 32'h0,         0, 1, JK,   32'h704,       32'h700,       NOP, 0, 16'd11);
        vec("miss_hit",  0, 0, 0, 0, 32'h0,         0, 0, IG,   32'h708,       32'h704,       IG,  1, 16'd11);
        vec("br_top",    0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, JK,   32'hFFFF_FFFC, 32'h704,       NOP, 0, 16'd12);
        vec("wrap",      0, 0, 0, 0, 32'h0,         0, 0, IH,   32'h0,         32'hFFFF_FFFC, IH,  1, 16'd12);
        vec("mr_80",     0, 0, 0, 1, 32'h80,        0, 1, JK,   32'h0,         32'hFFFF_FFFC, NOP, 0, 16'd13);
        vec("rst_mr",    1, 0, 0, 1, 32'h90,        0, 1, JK,   32'h0,         32'h0,         NOP, 0, 16'd0);
        vec("post_rst",  0, 0, 0, 0, 32'h0,         0, 0, IA,   32'h4,         32'h0,         IA,  1, 16'd0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
